// File: rtl/qspi_target_if.sv
// QSPI pin bundle between a host (master) and one memory responder (slave).
// Chip select and the four data lanes, split into pad input and driven output.
interface qspi_target_if;
    logic       cs_n;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;

    modport master (output cs_n, output io_in, input io_out, input io_oe);
    modport slave  (input cs_n, input io_in, output io_out, output io_oe);
endinterface

// File: rtl/qspi_target.sv
// QSPI memory responder: decodes SPI/QPI commands and serves quad read/write bursts
// from an internal byte array, one bit or nibble per clk.
module qspi_target #(
    parameter int PA        = 24,
    parameter int MEM_BYTES = 4096,
    parameter bit QUAD_RST  = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    qspi_target_if.slave bus,
    input  logic [4:0]   wait_cycles,
    output logic         quad_mode,
    output logic         busy
);
    localparam int          IDX_W     = $clog2(MEM_BYTES);
    localparam logic [23:0] ADDR_MASK = 24'((25'd1 << PA) - 25'd1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD_S, ST_CMD_Q, ST_ADDR, ST_WAIT, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  cmd_q, cmd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  wbuf_q, wbuf_d;
    logic        half_q, half_d;
    logic [4:0]  wait_q, wait_d;
    logic [3:0]  io_out_q, io_out_d;
    logic [3:0]  io_oe_q, io_oe_d;
    logic        quad_q, quad_d;

    logic [7:0]  mem [MEM_BYTES];
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  cmd_byte;
    logic        cmd_done;
    logic [23:0] addr_inc;

    assign mem_rdata = mem[addr_q[IDX_W-1:0]];
    assign addr_inc  = (addr_q + 24'd1) & ADDR_MASK;
    // The completing bit/nibble is merged combinationally so DECODE costs no extra clk.
    assign cmd_byte  = (state_q == ST_CMD_Q) ? {cmd_q[3:0], bus.io_in} : {cmd_q, bus.io_in[0]};
    assign cmd_done  = (state_q == ST_CMD_Q) || (state_q == ST_CMD_S && cnt_q == 3'd6);

    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        half_d    = half_q;
        wait_d    = wait_q;
        io_out_d  = io_out_q;
        io_oe_d   = 4'h0;
        quad_d    = quad_q;
        mem_we    = 1'b0;
        mem_wdata = {wbuf_q, bus.io_in};

        if (bus.cs_n) begin
            state_d  = ST_IDLE;
            io_out_d = 4'h0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = 3'd0;
                    if (quad_q) begin
                        cmd_d   = {3'b000, bus.io_in};
                        state_d = ST_CMD_Q;
                    end else begin
                        cmd_d   = {6'b000000, bus.io_in[0]};
                        state_d = ST_CMD_S;
                    end
                end
                ST_CMD_S: begin
                    cmd_d = cmd_byte[6:0];
                    cnt_d = 3'(cnt_q + 3'd1);
                end
                ST_CMD_Q: ;
                ST_ADDR: begin
                    addr_d = {addr_q[19:0], bus.io_in} & ADDR_MASK;
                    cnt_d  = 3'(cnt_q + 3'd1);
                    if (cnt_q == 3'd5) begin
                        half_d = 1'b0;
                        if (write_q) begin
                            state_d = ST_WDATA;
                        end else if (wait_cycles != 5'd0) begin
                            wait_d  = wait_cycles;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_RDATA;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_d = wait_q - 5'd1;
                    if (wait_q == 5'd1) state_d = ST_RDATA;
                end
                ST_RDATA: begin
                    io_oe_d = 4'hf;
                    half_d  = ~half_q;
                    if (!half_q) begin
                        io_out_d = mem_rdata[7:4];
                    end else begin
                        io_out_d = mem_rdata[3:0];
                        addr_d   = addr_inc;
                    end
                end
                ST_WDATA: begin
                    half_d = ~half_q;
                    if (!half_q) begin
                        wbuf_d = bus.io_in;
                    end else begin
                        mem_we = 1'b1;
                        addr_d = addr_inc;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase

            if (cmd_done) begin
                cnt_d   = 3'd0;
                state_d = ST_IGNORE;
                unique case (cmd_byte)
                    8'h38: begin write_d = 1'b1; state_d = ST_ADDR; end
                    8'hEB: begin write_d = 1'b0; state_d = ST_ADDR; end
                    8'h35: if (!quad_q) quad_d = 1'b1;
                    8'hF5: if (quad_q)  quad_d = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wbuf_q   <= '0;
            half_q   <= 1'b0;
            wait_q   <= '0;
            io_out_q <= '0;
            io_oe_q  <= '0;
            quad_q   <= QUAD_RST;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            half_q   <= half_d;
            wait_q   <= wait_d;
            io_out_q <= io_out_d;
            io_oe_q  <= io_oe_d;
            quad_q   <= quad_d;
        end
    end

    // NOTE: the array is deliberately not reset so it can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[IDX_W-1:0]] <= mem_wdata;
    end

    assign bus.io_out = io_out_q;
    assign bus.io_oe  = io_oe_q;
    assign quad_mode  = quad_q;
    assign busy       = (state_q != ST_IDLE);
endmodule
